// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, reset
// vector default, NOP encoding, the fetch FSM state type and an alignment
// helper used wherever a PC is about to be loaded.
`timescale 1ns/1ps
package if_stage_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_ERR   = 2'd2
  } fetch_state_t;

  // Instructions are word aligned, so the two low address bits must be zero.
  function automatic logic isAligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage. Holds the PC, issues one instruction-memory read
// per PC, latches the returned word and offers it to decode with a
// valid/ready handshake. The PC only advances when decode accepts and the
// control unit enables the PC write. A redirect (flush) beats everything but
// reset, and a misaligned target parks the stage in an error state until
// the next flush or reset.
`timescale 1ns/1ps
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] next_pc,
  input  logic              pc_wre,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  output logic [WORD_W-1:0] cur_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              addr_err,
  output logic [WORD_W-1:0] fetch_cnt
);

  fetch_state_t      r_state;
  logic              r_imemReq;
  logic              r_instrValid;
  logic              r_addrErr;
  logic [WORD_W-1:0] r_curPc;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_fetchCnt;

  logic w_capture;
  logic w_accept;
  logic w_acceptOk;
  logic w_flushOk;

  // Decode of this cycle's events; flush masking is applied in the register blocks.
  assign w_capture  = (r_state == S_FETCH) && imem_ack;
  assign w_accept   = (r_state == S_VALID) && instr_ready && pc_wre;
  assign w_acceptOk = w_accept && isAligned(next_pc);
  assign w_flushOk  = flush && isAligned(flush_pc);

  // Fetch FSM with registered request/valid/error outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= S_FETCH;
      r_imemReq    <= 1'b1;
      r_instrValid <= 1'b0;
      r_addrErr    <= 1'b0;
    end else if (flush) begin
      r_instrValid <= 1'b0;
      if (w_flushOk) begin
        r_state   <= S_FETCH;
        r_imemReq <= 1'b1;
        r_addrErr <= 1'b0;
      end else begin
        r_state   <= S_ERR;
        r_imemReq <= 1'b0;
        r_addrErr <= 1'b1;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_capture) begin
            r_state      <= S_VALID;
            r_imemReq    <= 1'b0;
            r_instrValid <= 1'b1;
          end
        end
        S_VALID: begin
          if (w_accept) begin
            r_instrValid <= 1'b0;
            if (w_acceptOk) begin
              r_state   <= S_FETCH;
              r_imemReq <= 1'b1;
            end else begin
              r_state   <= S_ERR;
              r_imemReq <= 1'b0;
              r_addrErr <= 1'b1;
            end
          end
        end
        S_ERR: begin
          r_imemReq    <= 1'b0;
          r_instrValid <= 1'b0;
        end
        default: begin
          r_state      <= S_FETCH;
          r_imemReq    <= 1'b1;
          r_instrValid <= 1'b0;
        end
      endcase
    end
  end

  // PC register: redirect wins over accept; misaligned targets leave it untouched.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_curPc <= RESET_PC;
    end else if (flush) begin
      if (w_flushOk) begin
        r_curPc <= flush_pc;
      end
    end else if (w_acceptOk) begin
      r_curPc <= next_pc;
    end
  end

  // Instruction latch: only a non-flushed ack in the fetch state captures data.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_instr <= NOP_INSTR;
    end else if (!flush && w_capture) begin
      r_instr <= imem_rdata;
    end
  end

  // Accepted-instruction counter; wraps silently at the top of its range.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_fetchCnt <= '0;
    end else if (!flush && w_accept) begin
      r_fetchCnt <= r_fetchCnt + 32'd1;
    end
  end

  assign cur_pc      = r_curPc;
  assign imem_req    = r_imemReq;
  assign imem_addr   = r_curPc;
  assign instr       = r_instr;
  assign instr_valid = r_instrValid;
  assign addr_err    = r_addrErr;
  assign fetch_cnt   = r_fetchCnt;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. Directed stimulus pushes the expected
// fetch addresses and accepted instructions into queues; a monitor pops and
// compares them whenever the DUT completes a memory read or a decode accept.
`timescale 1ns/1ps
module tb_if_stage;
  import if_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] next_pc = '0;
  logic        pc_wre = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [31:0] cur_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        addr_err;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] expAddrQ[$];
  logic [31:0] expInstrQ[$];

  logic [31:0] mPc;
  logic [31:0] mCnt;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .next_pc(next_pc), .pc_wre(pc_wre),
    .flush(flush), .flush_pc(flush_pc), .cur_pc(cur_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .addr_err(addr_err), .fetch_cnt(fetch_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return just after the rising edge.
  task automatic applyStimulus(input logic rst, input logic ack, input logic [31:0] rdata,
                               input logic rdy, input logic wre, input logic [31:0] npc,
                               input logic fl, input logic [31:0] fpc);
    RST = rst; imem_ack = ack; imem_rdata = rdata; instr_ready = rdy;
    pc_wre = wre; next_pc = npc; flush = fl; flush_pc = fpc;
    @(posedge CLK);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic fetchWord(input logic [31:0] data);
    expAddrQ.push_back(mPc);
    applyStimulus(1'b1, 1'b1, data, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic acceptWord(input logic [31:0] npc, input logic [31:0] expInstr);
    expInstrQ.push_back(expInstr);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, npc, 1'b0, 32'h0);
    mPc = npc;
    mCnt = mCnt + 32'd1;
  endtask

  task automatic flushTo(input logic [31:0] fpc, input logic ack);
    applyStimulus(1'b1, ack, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b1, fpc);
  endtask

  // Monitor: compare completed memory reads and decode accepts against the scoreboard.
  always @(negedge CLK) begin
    if (RST && !flush && imem_req && imem_ack) begin
      if (expAddrQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL fetchAddr: unexpected read at %h, none expected", imem_addr);
      end else begin
        checkOutput("fetchAddr", imem_addr, expAddrQ.pop_front());
      end
    end
    if (RST && !flush && instr_valid && instr_ready && pc_wre) begin
      if (expInstrQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL acceptInstr: unexpected accept of %h, none expected", instr);
      end else begin
        checkOutput("acceptInstr", instr, expInstrQ.pop_front());
      end
    end
  end

  initial begin
    mPc = 32'h0;
    mCnt = 32'h0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'h4, 1'b1, 32'h40);
    checkOutput("rstCurPc", cur_pc, 32'h0);
    checkOutput("rstCnt", fetch_cnt, 32'h0);
    checkOutput("rstInstr", instr, NOP_INSTR);
    checkFlag("rstErr", addr_err, 1'b0);
    checkFlag("rstValid", instr_valid, 1'b0);
    checkFlag("rstReq", imem_req, 1'b1);
    idleCycle();
    checkFlag("postRstReq", imem_req, 1'b1);
    checkOutput("postRstAddr", imem_addr, 32'h0);

    // Single-cycle memory, three accepts: 0, 4, 8
    for (int k = 0; k < 3; k++) begin
      fetchWord(32'h1000_0000 + 32'(k));
      checkFlag("seqValid", instr_valid, 1'b1);
      checkFlag("seqReqLow", imem_req, 1'b0);
      acceptWord(mPc + 32'd4, 32'h1000_0000 + 32'(k));
      checkFlag("seqReqAgain", imem_req, 1'b1);
      checkOutput("seqNextAddr", imem_addr, mPc);
    end
    checkOutput("seqCnt", fetch_cnt, 32'd3);

    // Decode backpressure at PC 12
    fetchWord(32'hA5A5_0003);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, mPc + 32'd4, 1'b0, 32'h0);
      checkOutput("bpInstr", instr, 32'hA5A5_0003);
      checkOutput("bpPc", cur_pc, 32'd12);
      checkFlag("bpValid", instr_valid, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, mPc + 32'd4, 1'b0, 32'h0);
    checkOutput("readyOnlyPc", cur_pc, 32'd12);
    checkFlag("readyOnlyValid", instr_valid, 1'b1);
    acceptWord(32'd16, 32'hA5A5_0003);
    checkOutput("bpAcceptPc", cur_pc, 32'd16);
    checkOutput("bpCnt", fetch_cnt, 32'd4);

    // Slow memory: three cycles without ack
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkFlag("slowReq", imem_req, 1'b1);
      checkFlag("slowValid", instr_valid, 1'b0);
    end
    fetchWord(32'h2002_0005);
    checkOutput("slowInstr", instr, 32'h2002_0005);
    checkFlag("slowValidUp", instr_valid, 1'b1);
    acceptWord(32'd20, 32'h2002_0005);
    checkOutput("slowCnt", fetch_cnt, 32'd5);

    // Flush with a simultaneous ack in the fetch state
    flushTo(32'h40, 1'b1);
    mPc = 32'h40;
    checkOutput("flushAddr", imem_addr, 32'h40);
    checkFlag("flushReq", imem_req, 1'b1);
    checkFlag("flushValid", instr_valid, 1'b0);
    checkOutput("flushCnt", fetch_cnt, 32'd5);
    checkOutput("flushInstrKept", instr, 32'h2002_0005);

    // Flush beats a same-cycle accept in the valid state
    fetchWord(32'h3000_0040);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 1'b1, 32'h80);
    mPc = 32'h80;
    checkOutput("flushPrioPc", cur_pc, 32'h80);
    checkOutput("flushPrioCnt", fetch_cnt, 32'd5);
    checkFlag("flushPrioValid", instr_valid, 1'b0);

    // Misaligned accept parks in the error state
    fetchWord(32'h4000_0080);
    expInstrQ.push_back(32'h4000_0080);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6, 1'b0, 32'h0);
    checkFlag("misErr", addr_err, 1'b1);
    checkFlag("misReq", imem_req, 1'b0);
    checkFlag("misValid", instr_valid, 1'b0);
    checkOutput("misPc", cur_pc, 32'h80);
    applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h84, 1'b0, 32'h0);
    checkFlag("errStickyErr", addr_err, 1'b1);
    checkFlag("errStickyReq", imem_req, 1'b0);
    checkOutput("errStickyPc", cur_pc, 32'h80);
    flushTo(32'h8, 1'b0);
    mPc = 32'h8;
    checkFlag("recoverErr", addr_err, 1'b0);
    checkFlag("recoverReq", imem_req, 1'b1);
    checkOutput("recoverAddr", imem_addr, 32'h8);

    // Misaligned flush target
    flushTo(32'h0000_000A, 1'b0);
    checkFlag("misFlushErr", addr_err, 1'b1);
    checkFlag("misFlushReq", imem_req, 1'b0);
    flushTo(32'h20, 1'b0);
    mPc = 32'h20;
    checkFlag("reflushErr", addr_err, 1'b0);
    checkOutput("reflushAddr", imem_addr, 32'h20);

    // Reset mid-fetch overrides flush, accept and ack
    idleCycle();
    applyStimulus(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1, 32'h24, 1'b1, 32'h100);
    mPc = 32'h0;
    mCnt = 32'h0;
    checkOutput("midRstPc", cur_pc, 32'h0);
    checkOutput("midRstCnt", fetch_cnt, 32'h0);
    checkOutput("midRstInstr", instr, NOP_INSTR);
    checkFlag("midRstErr", addr_err, 1'b0);
    checkFlag("midRstReq", imem_req, 1'b1);
    fetchWord(32'h5000_0000);
    checkOutput("postRstInstr", instr, 32'h5000_0000);
    acceptWord(32'h4, 32'h5000_0000);
    checkOutput("postRstCnt", fetch_cnt, mCnt);
    checkOutput("postRstPc", cur_pc, mPc);

    idleCycle();
    checkOutput("addrQEmpty", 32'(expAddrQ.size()), 32'h0);
    checkOutput("instrQEmpty", 32'(expInstrQ.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The module SHALL have port CLK, input, 1 bit, rising-edge clock.
REQ-003 The module SHALL have port RST, input, 1 bit, reset; synchronous, active-low.
REQ-004 The module SHALL have port next_pc, input, 32 bits, next-PC value from the PC adder.
REQ-005 The module SHALL have port pc_wre, input, 1 bit, PC write enable from the control unit.
REQ-006 The module SHALL have port flush, input, 1 bit, redirect request.
REQ-007 The module SHALL have port flush_pc, input, 32 bits, redirect target.
REQ-008 The module SHALL have port cur_pc, output, 32 bits, current PC; it feeds the PC adder.
REQ-009 The module SHALL have port imem_req, output, 1 bit, instruction-memory read request.
REQ-010 The module SHALL have port imem_addr, output, 32 bits, fetch address.
REQ-011 The module SHALL have port imem_ack, input, 1 bit, read-data-valid strobe.
REQ-012 The module SHALL have port imem_rdata, input, 32 bits, fetched word.
REQ-013 The module SHALL have port instr, output, 32 bits, latched instruction to decode.
REQ-014 The module SHALL have port instr_valid, output, 1 bit, instr holds a valid instruction.
REQ-015 The module SHALL have port instr_ready, input, 1 bit, decode accepts instr.
REQ-016 The module SHALL have port addr_err, output, 1 bit, sticky misaligned-PC flag.
REQ-017 The module SHALL have port fetch_cnt, output, 32 bits, count of accepted instructions.

Function
REQ-018 The FSM SHALL have states S_FETCH, S_VALID and S_ERR; the state SHALL change only on the CLK rising edge.
REQ-019 In S_FETCH: imem_req = 1, imem_addr = cur_pc, instr_valid = 0.
REQ-020 In S_FETCH with imem_ack = 1: instr <= imem_rdata, next state S_VALID; imem_ack = 0 holds S_FETCH with no timeout.
REQ-021 In S_VALID: imem_req = 0, instr_valid = 1; instr and cur_pc SHALL stay stable until the handshake completes.
REQ-022 Handshake: instr_ready && pc_wre in S_VALID means accept; cur_pc <= next_pc, fetch_cnt += 1, next state S_FETCH. instr_ready alone SHALL NOT advance the PC.
REQ-023 Accept latency: a new imem_req SHALL appear one cycle after the accept edge, with imem_addr equal to the new cur_pc.
REQ-024 Alignment: on accept, if next_pc[1:0] != 2'b00, then cur_pc is not updated, addr_err <= 1, and next state S_ERR.
REQ-025 S_ERR: imem_req = 0, instr_valid = 0; the FSM leaves S_ERR only by flush or reset.
REQ-026 flush = 1 in any state: cur_pc <= flush_pc, instr_valid = 0 on the next cycle, next state S_FETCH, addr_err cleared. An imem_ack in the same cycle SHALL be discarded, and fetch_cnt is not incremented.
REQ-027 flush SHALL have priority over accept and over imem_ack when they occur in the same cycle.
REQ-028 A flush_pc that is misaligned SHALL set addr_err and enter S_ERR.
REQ-029 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0 without a flag.
REQ-030 All outputs SHALL be driven from registers or decoded from state only; there SHALL be no combinational path from imem_rdata to instr.

Reset
REQ-031 RST = 0 sampled at a rising edge SHALL give: cur_pc = RESET_PC, state = S_FETCH, instr = 32'h0, addr_err = 0, fetch_cnt = 0.
REQ-032 Reset SHALL override flush, accept and imem_ack.
REQ-033 Reset asserted mid-fetch SHALL abandon the outstanding request; an imem_ack arriving on the first post-reset cycle SHALL be accepted as data for RESET_PC, so the memory must not ack stale requests.
REQ-034 imem_req SHALL be 1 on the first cycle after RST deasserts.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, RESET_PC default, the 32-bit word width constant and the NOP encoding 32'h0000_0000.
REQ-036 The block SHALL be a single module with no sub-module; the PC adder remains a separate instance that consumes cur_pc and returns next_pc.

Verification
REQ-037 Reset then single-cycle memory: the bench SHALL see imem_addr 0, then 4, then 8 on successive accepts, with fetch_cnt = 3 after three accepts.
REQ-038 Decode backpressure: with instr_ready = 0 for 5 cycles in S_VALID, instr, cur_pc and instr_valid = 1 SHALL hold; accept on cycle 6 sets cur_pc = next_pc.
REQ-039 Slow memory: with imem_ack delayed 3 cycles, imem_req SHALL stay high for 3 cycles, and instr SHALL equal imem_rdata 32'h2002_0005 in S_VALID.
REQ-040 Flush with simultaneous ack: with flush = 1, flush_pc = 32'h0000_0040 and imem_ack = 1 in the same cycle, the ack SHALL be dropped, the next imem_addr SHALL be 32'h40, and fetch_cnt SHALL be unchanged.
REQ-041 Misalignment: accept with next_pc = 32'h0000_0006 SHALL give addr_err = 1, S_ERR, imem_req = 0, and cur_pc unchanged; flush to 32'h8 SHALL recover.
REQ-042 Reset mid-fetch: RST = 0 while waiting for ack with cur_pc = 32'h20 SHALL restore cur_pc to RESET_PC, fetch_cnt = 0, and imem_req = 1 after release.
